// File: rtl/mem_poke_if.sv
// Request/acknowledge port to a 128-bit word memory, as seen by the mem_poke editor.
// The master drives address, requests and write data; the slave answers with valid/ack.
interface mem_poke_if;
   logic [14:0]  mem_address;
   logic         mem_rd_req;
   logic         mem_rd_valid;
   logic [127:0] mem_rd_data;
   logic         mem_wr_req;
   logic [127:0] mem_wr_data;
   logic         mem_wr_ack;

   modport master (
      output mem_address, mem_rd_req, mem_wr_req, mem_wr_data,
      input  mem_rd_valid, mem_rd_data, mem_wr_ack
   );

   modport slave (
      input  mem_address, mem_rd_req, mem_wr_req, mem_wr_data,
      output mem_rd_valid, mem_rd_data, mem_wr_ack
   );
endinterface

// File: rtl/mem_poke.sv
// Button-driven editor for one 128-bit memory word: fetch, nibble edit, commit back.
// Optional handshake timeout with sticky err flag is enabled by defining MEM_POKE_TIMEOUT_EN.
module mem_poke #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
`ifdef MEM_POKE_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       buttons,
   output logic [3:0]       output_led,
   output logic             busy,
   output logic             err,
   mem_poke_if.master       mem
);

   localparam int DBW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LOAD = DBW'(DEBOUNCE_CYCLES);

   typedef enum logic [2:0] {
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_EDIT,
      ST_WR_REQ,
      ST_WR_WAIT
   } state_t;

   logic [3:0]     meta_q, meta_d, sync_q, sync_d, level_q, level_d;
   logic [DBW-1:0] lock_q [4];
   logic [DBW-1:0] lock_d [4];
   logic [3:0]     pulse;

   state_t         state_q, state_d;
   logic [14:0]    mem_address_q, mem_address_d;
   logic [4:0]     sel_q, sel_d;
   logic [127:0]   edit_buf_q, edit_buf_d;
   logic           rd_req_q, rd_req_d;
   logic           wr_req_q, wr_req_d;
   logic           busy_q, busy_d;

`ifdef MEM_POKE_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]  timer_q, timer_d;
   logic           err_q, err_d;
`endif

   // Level changes are accepted only once the lockout has expired; only the press edge pulses.
   always_comb begin
      meta_d  = buttons;
      sync_d  = meta_q;
      level_d = level_q;
      pulse   = '0;
      for (int i = 0; i < 4; i++) begin
         lock_d[i] = lock_q[i];
         if (lock_q[i] != '0) begin
            lock_d[i] = lock_q[i] - DBW'(1);
         end else if (sync_q[i] != level_q[i]) begin
            level_d[i] = sync_q[i];
            lock_d[i]  = DB_LOAD;
            pulse[i]   = sync_q[i];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_address_d = mem_address_q;
      sel_d         = sel_q;
      edit_buf_d    = edit_buf_q;
      rd_req_d      = rd_req_q;
      wr_req_d      = wr_req_q;
`ifdef MEM_POKE_TIMEOUT_EN
      timer_d       = '0;
      err_d         = err_q;
`endif
      case (state_q)
         ST_RD_REQ: begin
            rd_req_d = 1'b1;
            state_d  = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (mem.mem_rd_valid) begin
               edit_buf_d = mem.mem_rd_data;
               rd_req_d   = 1'b0;
               state_d    = ST_EDIT;
`ifdef MEM_POKE_TIMEOUT_EN
               err_d      = 1'b0;
            end else if (timer_q == T_LAST) begin
               rd_req_d   = 1'b0;
               err_d      = 1'b1;
               state_d    = ST_EDIT;
            end else begin
               timer_d    = timer_q + TW'(1);
`endif
            end
         end
         ST_EDIT: begin
            // Highest-numbered pulse wins; the rest of that cycle's pulses are lost.
            if (pulse[3]) begin
               state_d = ST_WR_REQ;
            end else if (pulse[2]) begin
               mem_address_d = mem_address_q + 15'd1;
               state_d       = ST_RD_REQ;
            end else if (pulse[1]) begin
               sel_d = sel_q + 5'd1;
            end else if (pulse[0]) begin
               edit_buf_d[{sel_q, 2'b00} +: 4] = edit_buf_q[{sel_q, 2'b00} +: 4] + 4'd1;
            end
         end
         ST_WR_REQ: begin
            wr_req_d = 1'b1;
            state_d  = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (mem.mem_wr_ack) begin
               wr_req_d = 1'b0;
               state_d  = ST_EDIT;
`ifdef MEM_POKE_TIMEOUT_EN
               err_d    = 1'b0;
            end else if (timer_q == T_LAST) begin
               wr_req_d = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_EDIT;
            end else begin
               timer_d  = timer_q + TW'(1);
`endif
            end
         end
         default: begin
            state_d = ST_RD_REQ;
         end
      endcase
      busy_d = (state_d != ST_EDIT);
   end

   // busy is registered so it reads 0 on the reset edge even though the FSM restarts busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q        <= '0;
         sync_q        <= '0;
         level_q       <= '0;
         for (int i = 0; i < 4; i++) begin
            lock_q[i] <= '0;
         end
         state_q       <= ST_RD_REQ;
         mem_address_q <= '0;
         sel_q         <= '0;
         edit_buf_q    <= '0;
         rd_req_q      <= 1'b0;
         wr_req_q      <= 1'b0;
         busy_q        <= 1'b0;
`ifdef MEM_POKE_TIMEOUT_EN
         timer_q       <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         meta_q        <= meta_d;
         sync_q        <= sync_d;
         level_q       <= level_d;
         for (int i = 0; i < 4; i++) begin
            lock_q[i] <= lock_d[i];
         end
         state_q       <= state_d;
         mem_address_q <= mem_address_d;
         sel_q         <= sel_d;
         edit_buf_q    <= edit_buf_d;
         rd_req_q      <= rd_req_d;
         wr_req_q      <= wr_req_d;
         busy_q        <= busy_d;
`ifdef MEM_POKE_TIMEOUT_EN
         timer_q       <= timer_d;
         err_q         <= err_d;
`endif
      end
   end

   assign output_led      = edit_buf_q[{sel_q, 2'b00} +: 4];
   assign busy            = busy_q;
   assign mem.mem_address = mem_address_q;
   assign mem.mem_rd_req  = rd_req_q;
   assign mem.mem_wr_req  = wr_req_q;
   assign mem.mem_wr_data = edit_buf_q;
`ifdef MEM_POKE_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_poke.sv
// Self-checking bench for mem_poke: a memory responder plus a word/nibble-level model of the editor.
// Define MEM_POKE_TIMEOUT_EN to exercise the timeout build (TIMEOUT_CYCLES overridden to 8).
module tb_mem_poke;
   logic       clk;
   logic       rst;
   logic [3:0] buttons;
   logic [3:0] output_led;
   logic       busy;
   logic       err;

   mem_poke_if mem_bus();

   mem_poke #(
      .DEBOUNCE_CYCLES(4)
`ifdef MEM_POKE_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .buttons    (buttons),
      .output_led (output_led),
      .busy       (busy),
      .err        (err),
      .mem        (mem_bus)
   );

   int errors = 0;
   int checks = 0;

   // Responder controls and the external memory contents the model believes in
   bit           rd_hold = 0;
   bit           wr_hold = 0;
   int           rd_delay = 0;
   int           wr_delay = 0;
   logic [127:0] last_wr_data = '0;
   logic [14:0]  last_wr_addr = '0;
   logic [127:0] model_mem [int];

   // Editor model
   int           m_addr = 0;
   int           m_sel = 0;
   logic [127:0] m_buf = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [127:0] fill(input int a);
      logic [31:0] x;
      x = 32'(a) * 32'h9E3779B1 + 32'h01234567;
      return {x, ~x, x ^ 32'hA5A5A5A5, x + 32'd7};
   endfunction

   function automatic logic [127:0] mem_read(input int a);
      if (model_mem.exists(a)) return model_mem[a];
      return fill(a);
   endfunction

   function automatic logic [3:0] nib(input logic [127:0] w, input int s);
      logic [127:0] t;
      t = (w >> (4 * s)) & 128'hF;
      return t[3:0];
   endfunction

   function automatic logic [127:0] bump(input logic [127:0] w, input int s);
      int n;
      n = (int'(nib(w, s)) + 1) % 16;
      return (w & ~(128'hF << (4 * s))) | (128'(n) << (4 * s));
   endfunction

   // Memory slave: answers requests after a programmable delay, driving on the falling edge
   initial begin : responder
      int rd_cnt;
      int wr_cnt;
      rd_cnt = 0;
      wr_cnt = 0;
      mem_bus.mem_rd_valid = 1'b0;
      mem_bus.mem_rd_data  = '0;
      mem_bus.mem_wr_ack   = 1'b0;
      forever begin
         @(negedge clk);
         mem_bus.mem_rd_valid = 1'b0;
         mem_bus.mem_wr_ack   = 1'b0;
         if (mem_bus.mem_rd_req && !rd_hold) begin
            if (rd_cnt >= rd_delay) begin
               mem_bus.mem_rd_valid = 1'b1;
               mem_bus.mem_rd_data  = mem_read(int'(mem_bus.mem_address));
               rd_cnt = 0;
            end else rd_cnt++;
         end else rd_cnt = 0;
         if (mem_bus.mem_wr_req && !wr_hold) begin
            if (wr_cnt >= wr_delay) begin
               mem_bus.mem_wr_ack = 1'b1;
               last_wr_data = mem_bus.mem_wr_data;
               last_wr_addr = mem_bus.mem_address;
               wr_cnt = 0;
            end else wr_cnt++;
         end else wr_cnt = 0;
      end
   end

   task automatic press(input logic [3:0] mask);
      @(negedge clk);
      buttons = mask;
      repeat (3) @(negedge clk);
      buttons = 4'h0;
      repeat (14) @(negedge clk);
   endtask

   task automatic press_bounce(input logic [3:0] mask);
      logic [4:0] pattern;
      pattern = 5'b10101;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         buttons = pattern[i] ? mask : 4'h0;
      end
      repeat (3) @(negedge clk);
      buttons = 4'h0;
      repeat (14) @(negedge clk);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      buttons = 4'h0;
      rd_delay = 2;
      repeat (3) @(negedge clk);
      checks++; if (mem_bus.mem_rd_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_req: got %b expected 0", mem_bus.mem_rd_req); end
      checks++; if (mem_bus.mem_wr_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_req: got %b expected 0", mem_bus.mem_wr_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      checks++; if (output_led !== 4'h0) begin errors++; $display("[TB] FAIL reset_led: got %h expected 0", output_led); end
      checks++; if (mem_bus.mem_address !== 15'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_bus.mem_address); end
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_bus.mem_rd_req) begin
            if (cnt == 0) begin
               checks++; if (mem_bus.mem_address !== 15'h0) begin errors++; $display("[TB] FAIL boot_read_addr: got %h expected 0", mem_bus.mem_address); end
            end
            cnt++;
         end else if (cnt > 0) break;
      end
      m_addr = 0;
      m_sel = 0;
      m_buf = mem_read(0);
      checks++; if (cnt != 3) begin errors++; $display("[TB] FAIL boot_rd_req_cycles: got %0d expected 3", cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL boot_busy: got %b expected 0", busy); end
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL boot_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
   endtask

   task automatic test_edit();
      press(4'b0010);
      press(4'b0010);
      m_sel = 2;
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL sel_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
      for (int k = 0; k < 3; k++) begin
         press(4'b0001);
         m_buf = bump(m_buf, m_sel);
         checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL inc_led_%0d: got %h expected %h", k, output_led, nib(m_buf, m_sel)); end
      end
      checks++; if (output_led !== 4'h0) begin errors++; $display("[TB] FAIL inc_wrap: got %h expected 0", output_led); end
   endtask

   task automatic test_commit();
      bit ok;
      wr_hold = 1'b1;
      wr_delay = 0;
      press(4'b1000);
      checks++; if (mem_bus.mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL commit_wr_req: got %b expected 1", mem_bus.mem_wr_req); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL commit_busy: got %b expected 1", busy); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (mem_bus.mem_wr_data !== m_buf) begin errors++; $display("[TB] FAIL commit_wr_data_%0d: got %h expected %h", i, mem_bus.mem_wr_data, m_buf); end
         checks++; if (mem_bus.mem_address !== 15'(m_addr)) begin errors++; $display("[TB] FAIL commit_addr_%0d: got %h expected %h", i, mem_bus.mem_address, 15'(m_addr)); end
      end
      wr_hold = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!mem_bus.mem_wr_req) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("[TB] FAIL commit_req_drop: got held expected dropped"); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL commit_idle: got %b expected 0", busy); end
      checks++; if (last_wr_data !== m_buf) begin errors++; $display("[TB] FAIL commit_written: got %h expected %h", last_wr_data, m_buf); end
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL commit_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
      model_mem[m_addr] = m_buf;
   endtask

   task automatic test_addr_wrap();
      bit ok;
      @(negedge clk);
      force dut.mem_address_q = 15'h7FFF;
      @(negedge clk);
      release dut.mem_address_q;
      m_addr = 32767;
      checks++; if (mem_bus.mem_address !== 15'h7FFF) begin errors++; $display("[TB] FAIL wrap_preset: got %h expected 7fff", mem_bus.mem_address); end
      rd_hold = 1'b1;
      press(4'b0100);
      m_addr = (m_addr + 1) % 32768;
      checks++; if (mem_bus.mem_address !== 15'(m_addr)) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected %h", mem_bus.mem_address, 15'(m_addr)); end
      checks++; if (mem_bus.mem_rd_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_rd_req: got %b expected 1", mem_bus.mem_rd_req); end
      rd_hold = 1'b0;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_idle: got busy expected idle"); end
      m_buf = mem_read(m_addr);
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL wrap_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
   endtask

   task automatic test_priority();
      bit ok;
      wr_hold = 1'b1;
      wr_delay = 1;
      press(4'b1001);
      checks++; if (mem_bus.mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_wr_req: got %b expected 1", mem_bus.mem_wr_req); end
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL prio_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
      press(4'b0001);
      checks++; if (mem_bus.mem_wr_data !== m_buf) begin errors++; $display("[TB] FAIL busy_press_data: got %h expected %h", mem_bus.mem_wr_data, m_buf); end
      wr_hold = 1'b0;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL prio_idle: got busy expected idle"); end
      checks++; if (last_wr_data !== m_buf) begin errors++; $display("[TB] FAIL prio_written: got %h expected %h", last_wr_data, m_buf); end
      model_mem[m_addr] = m_buf;
      press(4'b0011);
      m_sel = (m_sel + 1) % 32;
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL prio_sel_over_inc: got %h expected %h", output_led, nib(m_buf, m_sel)); end
      press(4'b0110);
      wait_idle(ok);
      m_addr = (m_addr + 1) % 32768;
      m_buf = mem_read(m_addr);
      checks++; if (mem_bus.mem_address !== 15'(m_addr)) begin errors++; $display("[TB] FAIL prio_addr_over_sel: got %h expected %h", mem_bus.mem_address, 15'(m_addr)); end
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL prio_addr_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
   endtask

   task automatic test_bounce();
      press_bounce(4'b0001);
      m_buf = bump(m_buf, m_sel);
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL bounce_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
      press_bounce(4'b0010);
      m_sel = (m_sel + 1) % 32;
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL bounce_sel_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
   endtask

   task automatic test_random();
      bit ok;
      int r;
      for (int n = 0; n < 24; n++) begin
         rd_delay = $urandom_range(0, 3);
         wr_delay = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            press(4'b0001);
            m_buf = bump(m_buf, m_sel);
         end else if (r <= 7) begin
            press(4'b0010);
            m_sel = (m_sel + 1) % 32;
         end else if (r == 8) begin
            press(4'b0100);
            m_addr = (m_addr + 1) % 32768;
            m_buf = mem_read(m_addr);
         end else begin
            press(4'b1000);
         end
         wait_idle(ok);
         checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_idle_%0d: got busy expected idle", n); end
         if (r == 9) begin
            checks++; if (last_wr_data !== m_buf || last_wr_addr !== 15'(m_addr)) begin errors++; $display("[TB] FAIL rand_write_%0d: got %h@%h expected %h@%h", n, last_wr_data, last_wr_addr, m_buf, 15'(m_addr)); end
            model_mem[m_addr] = m_buf;
         end
         checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL rand_led_%0d: got %h expected %h", n, output_led, nib(m_buf, m_sel)); end
         checks++; if (mem_bus.mem_address !== 15'(m_addr)) begin errors++; $display("[TB] FAIL rand_addr_%0d: got %h expected %h", n, mem_bus.mem_address, 15'(m_addr)); end
      end
   endtask

`ifdef MEM_POKE_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int cnt;
      wr_hold = 1'b1;
      cnt = 0;
      fork
         press(4'b1000);
         begin
            for (int i = 0; i < 60; i++) begin
               @(negedge clk);
               if (mem_bus.mem_wr_req) cnt++;
               else if (cnt > 0) break;
            end
            checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy); end
         end
      join
      wr_hold = 1'b0;
      checks++; if (cnt != 8) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 8", cnt); end
      press(4'b0010);
      m_sel = (m_sel + 1) % 32;
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", err); end
      press(4'b0100);
      wait_idle(ok);
      m_addr = (m_addr + 1) % 32768;
      m_buf = mem_read(m_addr);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %b expected 0", err); end
      checks++; if (output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL timeout_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
   endtask
`else
   task automatic test_no_timeout();
      bit ok;
      wr_hold = 1'b1;
      press(4'b1000);
      repeat (30) @(negedge clk);
      checks++; if (mem_bus.mem_wr_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_forever_req: got %b expected 1", mem_bus.mem_wr_req); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL wait_forever_err: got %b expected 0", err); end
      wr_hold = 1'b0;
      wait_idle(ok);
      checks++; if (!ok || last_wr_data !== m_buf) begin errors++; $display("[TB] FAIL wait_forever_write: got %h expected %h", last_wr_data, m_buf); end
      model_mem[m_addr] = m_buf;
   endtask
`endif

   task automatic test_reset_mid();
      bit ok;
      rd_hold = 1'b1;
      press(4'b0100);
      checks++; if (mem_bus.mem_rd_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_rd_req: got %b expected 1", mem_bus.mem_rd_req); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (mem_bus.mem_rd_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_drop: got %b expected 0", mem_bus.mem_rd_req); end
      checks++; if (busy !== 1'b0 || output_led !== 4'h0 || mem_bus.mem_address !== 15'h0) begin errors++; $display("[TB] FAIL mid_reset_state: got busy=%b led=%h addr=%h expected 0/0/0", busy, output_led, mem_bus.mem_address); end
      rst = 1'b0;
      rd_hold = 1'b0;
      repeat (2) @(negedge clk);
      wait_idle(ok);
      m_addr = 0;
      m_sel = 0;
      m_buf = mem_read(0);
      checks++; if (!ok || output_led !== nib(m_buf, m_sel)) begin errors++; $display("[TB] FAIL mid_reread_led: got %h expected %h", output_led, nib(m_buf, m_sel)); end
   endtask

   initial begin
      model_mem[0] = 128'h0123456789ABCDEF;
      buttons = 4'h0;
      rst = 1'b1;
      test_reset();
      test_edit();
      test_commit();
      test_addr_wrap();
      test_priority();
      test_bounce();
      test_random();
`ifdef MEM_POKE_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
